// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver: FSM state
// encoding, parity-mode constants and a width-aware parity helper.
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   // Parity sense applied on top of the plain XOR of the data bits
   localparam logic PARITY_MODE_EVEN = 1'b0;
   localparam logic PARITY_MODE_ODD  = 1'b1;

   // Widest data word the receiver supports
   localparam int MAX_DATA_BITS = 9;

   // XOR of the low nbits bits of word; bits above nbits are ignored so
   // narrower words can be passed zero-extended.
   function automatic logic word_parity(input logic [MAX_DATA_BITS-1:0] word,
                                        input int nbits);
      logic p;
      p = 1'b0;
      for (int i = 0; i < MAX_DATA_BITS; i++) begin
         if (i < nbits) begin
            p = p ^ word[i];
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Small synchronous receive FIFO with a registered head word. The head
// register is loaded directly from the write data when the FIFO is (or is
// about to become) empty, so a push is visible on the outputs one cycle later.
module uart_rx_fifo #(
   parameter int WIDTH = 10,
   parameter int DEPTH = 4
) (
   input  logic             clk_50m,
   input  logic             rst,
   input  logic             push_i,
   input  logic [WIDTH-1:0] push_data_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] head_o,
   output logic             valid_o,
   output logic             full_o
);

   localparam int          AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [AW:0]      count_q, count_d, count_after_pop;
   logic [WIDTH-1:0] head_q, head_d;
   logic             valid_q;
   logic             do_pop, do_push;

   // Accept/retire decisions and the next head word
   always_comb begin
      do_pop          = pop_i & (count_q != '0);
      do_push         = push_i & ((count_q != DEPTH_C) | do_pop);
      count_after_pop = count_q - (AW+1)'(do_pop);
      count_d         = count_after_pop + (AW+1)'(do_push);
      rd_ptr_d        = rd_ptr_q + AW'(do_pop);
      wr_ptr_d        = wr_ptr_q + AW'(do_push);
      head_d          = head_q;
      if (count_after_pop == '0) begin
         // Nothing left behind the head: the incoming word becomes the head
         if (do_push) begin
            head_d = push_data_i;
         end
      end else begin
         head_d = mem_q[rd_ptr_d];
      end
   end

   // Storage write; contents need no reset because count_q gates every read
   always_ff @(posedge clk_50m) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_data_i;
      end
   end

   // Pointers, occupancy and the registered head/valid outputs
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         head_q   <= '0;
         valid_q  <= 1'b0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         head_q   <= head_d;
         valid_q  <= (count_d != '0);
      end
   end

   assign head_o  = head_q;
   assign valid_o = valid_q;
   assign full_o  = (count_q == DEPTH_C);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: 2-FF input synchroniser, 3-sample majority
// vote around each bit centre, start/data/parity/stop FSM, per-word error
// flags, a small receive FIFO and a sticky overrun flag.
module uart_rx_param
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int OVERSAMPLE = 16,
   parameter int PARITY_EN  = 0,
   parameter int PARITY_ODD = 0,
   parameter int STOP_BITS  = 1,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                 clk_50m,
   input  logic                 rst,
   input  logic                 clken,
   input  logic                 rx,
   input  logic                 rd_en,
   input  logic                 overrun_clr,
   output logic [DATA_BITS-1:0] data,
   output logic                 valid,
   output logic                 parity_err,
   output logic                 frame_err,
   output logic                 overrun,
   output logic                 busy
);

   localparam int                SCNT_W        = $clog2(OVERSAMPLE);
   localparam logic [SCNT_W-1:0] TICK_S0       = SCNT_W'(OVERSAMPLE/2 - 1);
   localparam logic [SCNT_W-1:0] TICK_S1       = SCNT_W'(OVERSAMPLE/2);
   localparam logic [SCNT_W-1:0] TICK_VOTE     = SCNT_W'(OVERSAMPLE/2 + 1);
   localparam logic [SCNT_W-1:0] TICK_LAST     = SCNT_W'(OVERSAMPLE - 1);
   localparam int                BCNT_W        = 4;
   localparam logic [BCNT_W-1:0] LAST_DATA_BIT = BCNT_W'(DATA_BITS - 1);
   localparam logic              LAST_STOP     = 1'(STOP_BITS - 1);
   localparam logic              PARITY_SENSE  = (PARITY_ODD != 0) ? PARITY_MODE_ODD
                                                                    : PARITY_MODE_EVEN;
   localparam rx_state_e         AFTER_DATA    = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
   localparam int                FIFO_W        = DATA_BITS + 2;

   // Synchroniser
   logic rx_meta_q, rx_s_q;

   // FSM and datapath registers
   rx_state_e            state_q;
   logic [SCNT_W-1:0]    scnt_q;
   logic [BCNT_W-1:0]    bcnt_q;
   logic                 stop_cnt_q;
   logic                 samp0_q, samp1_q;
   logic [DATA_BITS-1:0] shreg_q;
   logic                 perr_q, ferr_q;
   logic                 busy_q;
   logic                 overrun_q;

   // Decoded ticks and vote
   logic              tick_s0, tick_s1, tick_vote, tick_last;
   logic              vote_bit;
   logic [SCNT_W-1:0] scnt_d;
   logic              data_parity;
   logic              push;
   logic [FIFO_W-1:0] push_word;

   // FIFO side
   logic [FIFO_W-1:0] fifo_head;
   logic              fifo_valid;
   logic              fifo_full;

   // Two-flop synchroniser; both stages idle high so reset never looks like a start bit
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
      end
   end

   // Sample-window decode, majority vote and the word/flags offered to the FIFO
   always_comb begin
      tick_s0     = clken & (scnt_q == TICK_S0);
      tick_s1     = clken & (scnt_q == TICK_S1);
      tick_vote   = clken & (scnt_q == TICK_VOTE);
      tick_last   = clken & (scnt_q == TICK_LAST);
      scnt_d      = (scnt_q == TICK_LAST) ? '0 : scnt_q + 1'b1;
      vote_bit    = (samp0_q & samp1_q) | (samp0_q & rx_s_q) | (samp1_q & rx_s_q);
      data_parity = word_parity(MAX_DATA_BITS'(shreg_q), DATA_BITS);
      // The final stop bit's vote completes the frame; its own error is folded in here
      push        = (state_q == ST_STOP) & tick_vote & (stop_cnt_q == LAST_STOP);
      push_word   = {perr_q, ferr_q | ~vote_bit, shreg_q};
   end

   // Receiver FSM with registered busy output
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         scnt_q     <= '0;
         bcnt_q     <= '0;
         stop_cnt_q <= 1'b0;
         samp0_q    <= 1'b1;
         samp1_q    <= 1'b1;
         shreg_q    <= '0;
         perr_q     <= 1'b0;
         ferr_q     <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         if (tick_s0) begin
            samp0_q <= rx_s_q;
         end
         if (tick_s1) begin
            samp1_q <= rx_s_q;
         end
         if (clken && (state_q != ST_IDLE)) begin
            scnt_q <= scnt_d;
         end
         case (state_q)
            ST_IDLE: begin
               if (clken && !rx_s_q) begin
                  state_q    <= ST_START;
                  scnt_q     <= '0;
                  bcnt_q     <= '0;
                  stop_cnt_q <= 1'b0;
                  perr_q     <= 1'b0;
                  ferr_q     <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            ST_START: begin
               if (tick_vote && vote_bit) begin
                  // Line went back high before the centre: treat as noise
                  state_q <= ST_IDLE;
                  busy_q  <= 1'b0;
               end else if (tick_last) begin
                  state_q <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (tick_vote) begin
                  shreg_q <= {vote_bit, shreg_q[DATA_BITS-1:1]};
               end
               if (tick_last) begin
                  if (bcnt_q == LAST_DATA_BIT) begin
                     bcnt_q  <= '0;
                     state_q <= AFTER_DATA;
                  end else begin
                     bcnt_q <= bcnt_q + 1'b1;
                  end
               end
            end
            ST_PARITY: begin
               if (tick_vote) begin
                  perr_q <= vote_bit ^ data_parity ^ PARITY_SENSE;
               end
               if (tick_last) begin
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               if (tick_vote) begin
                  if (stop_cnt_q == LAST_STOP) begin
                     // Word is pushed this cycle; do not wait for the bit to end
                     state_q <= ST_IDLE;
                     busy_q  <= 1'b0;
                  end else begin
                     ferr_q <= ferr_q | ~vote_bit;
                  end
               end else if (tick_last) begin
                  stop_cnt_q <= 1'b1;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Sticky overrun: a push into a full FIFO that is not being read this cycle; set beats clear
   always_ff @(posedge clk_50m) begin
      if (rst) begin
         overrun_q <= 1'b0;
      end else if (push && fifo_full && !rd_en) begin
         overrun_q <= 1'b1;
      end else if (overrun_clr) begin
         overrun_q <= 1'b0;
      end
   end

   uart_rx_fifo #(
      .WIDTH (FIFO_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk_50m     (clk_50m),
      .rst         (rst),
      .push_i      (push),
      .push_data_i (push_word),
      .pop_i       (rd_en),
      .head_o      (fifo_head),
      .valid_o     (fifo_valid),
      .full_o      (fifo_full)
   );

   assign data       = fifo_head[DATA_BITS-1:0];
   assign frame_err  = fifo_head[DATA_BITS];
   assign parity_err = fifo_head[DATA_BITS+1];
   assign valid      = fifo_valid;
   assign overrun    = overrun_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_uart_rx_param.sv
// Self-checking bench for uart_rx_param (8 data bits, even parity, 2 stop
// bits, 4-deep FIFO, one oversample tick every 2 clocks). Expected words,
// flags, overrun and busy-pulse lengths come from a frame-level model.
module tb_uart_rx_param;

   localparam int   TB_DB    = 8;
   localparam int   TB_OS    = 16;
   localparam int   TB_PEN   = 1;
   localparam logic TB_PODD  = 1'b0;
   localparam int   TB_SB    = 2;
   localparam int   TB_DEPTH = 4;
   localparam int   TB_DIV   = 2;
   localparam int   BIT_CYC  = TB_OS * TB_DIV;
   // The entry tick sets the counter to 0, so the tick that sees count c is
   // c+1 ticks after entry; bit n (start bit n=0) is voted n*OS + OS/2+2 ticks in.
   localparam int   FRAME_BUSY = ((1 + TB_DB + TB_PEN + TB_SB - 1) * TB_OS + TB_OS/2 + 2) * TB_DIV;
   localparam int   FALSE_BUSY = (TB_OS/2 + 2) * TB_DIV;

   logic       clk, rst, clken, rx, rd_en, overrun_clr;
   logic [7:0] data;
   logic       valid, parity_err, frame_err, overrun, busy;

   int n_cmp = 0;
   int n_bad = 0;

   logic [9:0] exp_q[$];   // {parity_err, frame_err, data}
   logic       model_ovr = 1'b0;
   int         busy_len_q[$];

   uart_rx_param #(
      .DATA_BITS  (TB_DB),
      .OVERSAMPLE (TB_OS),
      .PARITY_EN  (TB_PEN),
      .PARITY_ODD (0),
      .STOP_BITS  (TB_SB),
      .FIFO_DEPTH (TB_DEPTH)
   ) dut (
      .clk_50m     (clk),
      .rst         (rst),
      .clken       (clken),
      .rx          (rx),
      .rd_en       (rd_en),
      .overrun_clr (overrun_clr),
      .data        (data),
      .valid       (valid),
      .parity_err  (parity_err),
      .frame_err   (frame_err),
      .overrun     (overrun),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Oversample tick: high every other clock
   initial begin
      clken = 1'b0;
      forever begin
         @(posedge clk);
         #1 clken = ~clken;
      end
   end

   // Record the length (in clocks) of every busy pulse
   initial begin
      int run;
      run = 0;
      forever begin
         @(posedge clk);
         #1;
         if (busy) begin
            run++;
         end else if (run > 0) begin
            busy_len_q.push_back(run);
            run = 0;
         end
      end
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
      $fatal(1, "watchdog");
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic good_par(input logic [7:0] d);
      return (^d) ^ TB_PODD;
   endfunction

   task automatic wait_cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Hold one bit on the line; optionally invert it for one tick near the centre
   task automatic drive_bit(input logic b, input bit glitch);
      rx = b;
      if (!glitch) begin
         repeat (BIT_CYC) @(posedge clk);
      end else begin
         repeat (18) @(posedge clk);
         #1 rx = ~b;
         repeat (2) @(posedge clk);
         #1 rx = b;
         repeat (BIT_CYC - 20) @(posedge clk);
      end
      #1;
   endtask

   task automatic expect_busy(input string tag, input int len);
      int got;
      got = (busy_len_q.size() == 0) ? 0 : busy_len_q.pop_front();
      check_val(tag, got, len);
   endtask

   // Send one full frame, then update the model and check busy timing
   task automatic send_frame(input logic [7:0] d, input logic pb, input logic s0,
                             input logic s1, input int g);
      logic perr, ferr, last;
      drive_bit(1'b0, 1'b0);
      for (int i = 0; i < TB_DB; i++) begin
         drive_bit(d[i], i == g);
      end
      if (TB_PEN != 0) drive_bit(pb, 1'b0);
      drive_bit(s0, 1'b0);
      if (TB_SB == 2) drive_bit(s1, 1'b0);
      rx = 1'b1;
      wait_cyc(24);
      perr = (pb != good_par(d));
      ferr = !s0 || ((TB_SB == 2) && !s1);
      last = (TB_SB == 2) ? s1 : s0;
      if (exp_q.size() < TB_DEPTH) exp_q.push_back({perr, ferr, d});
      else model_ovr = 1'b1;
      expect_busy("busy_len", FRAME_BUSY);
      // A low final stop bit is still low after the push and looks like a start
      if (!last) expect_busy("busy_len_tail", FALSE_BUSY);
   endtask

   task automatic pop_check(input string tag);
      logic [9:0] e;
      if (exp_q.size() == 0) begin
         check_val({tag, "_valid_empty"}, valid, 0);
         return;
      end
      e = exp_q[0];
      check_val({tag, "_valid"}, valid, 1);
      check_val({tag, "_data"}, data, e[7:0]);
      check_val({tag, "_perr"}, parity_err, e[9]);
      check_val({tag, "_ferr"}, frame_err, e[8]);
      rd_en = 1'b1;
      @(posedge clk);
      #1 rd_en = 1'b0;
      void'(exp_q.pop_front());
      check_val({tag, "_valid_after"}, valid, exp_q.size() > 0);
   endtask

   task automatic clear_overrun(input string tag);
      overrun_clr = 1'b1;
      @(posedge clk);
      #1 overrun_clr = 1'b0;
      model_ovr = 1'b0;
      check_val(tag, overrun, 0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check_val({tag, "_data"}, data, 0);
      check_val({tag, "_valid"}, valid, 0);
      check_val({tag, "_perr"}, parity_err, 0);
      check_val({tag, "_ferr"}, frame_err, 0);
      check_val({tag, "_ovr"}, overrun, 0);
      check_val({tag, "_busy"}, busy, 0);
   endtask

   initial begin
      rst = 1'b1;
      rx = 1'b1;
      rd_en = 1'b0;
      overrun_clr = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      wait_cyc(4);

      // Clean frame
      send_frame(8'hA5, good_par(8'hA5), 1'b1, 1'b1, -1);
      check_val("a5_busy_low", busy, 0);
      pop_check("a5");

      // False start: low for 4 ticks only
      rx = 1'b0;
      wait_cyc(4 * TB_DIV);
      rx = 1'b1;
      wait_cyc(40);
      expect_busy("fs_busy_len", FALSE_BUSY);
      check_val("fs_no_push", valid, 0);
      send_frame(8'h5A, good_par(8'h5A), 1'b1, 1'b1, -1);
      pop_check("5a");

      // One-tick glitch on a data bit centre
      send_frame(8'h96, good_par(8'h96), 1'b1, 1'b1, 3);
      pop_check("glitch");

      // Parity: 0x07 with wrong then right parity bit
      send_frame(8'h07, 1'b0, 1'b1, 1'b1, -1);
      pop_check("par_bad");
      send_frame(8'h07, 1'b1, 1'b1, 1'b1, -1);
      pop_check("par_good");

      // Framing: first stop low, then second stop low, then a break
      send_frame(8'h3C, good_par(8'h3C), 1'b0, 1'b1, -1);
      send_frame(8'h3C, good_par(8'h3C), 1'b1, 1'b0, -1);
      send_frame(8'h00, 1'b0, 1'b0, 1'b0, -1);
      pop_check("stop0");
      pop_check("stop1");
      pop_check("break");

      // Overrun: five frames into a four-deep FIFO
      for (int i = 1; i <= 5; i++) begin
         send_frame(8'(i), good_par(8'(i)), 1'b1, 1'b1, -1);
      end
      check_val("ovr_set", overrun, model_ovr);
      for (int i = 0; i < 5; i++) pop_check("ovr_drain");
      check_val("ovr_sticky", overrun, model_ovr);
      clear_overrun("ovr_clr");

      // Push on the same cycle as a read while full: no overrun
      for (int i = 0; i < TB_DEPTH; i++) begin
         send_frame(8'h10 + 8'(i), good_par(8'h10 + 8'(i)), 1'b1, 1'b1, -1);
      end
      check_val("cc_head", data, exp_q[0][7:0]);
      void'(exp_q.pop_front());
      fork
         send_frame(8'h77, good_par(8'h77), 1'b1, 1'b1, -1);
         begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 400 && !seen; k++) begin
               @(posedge clk);
               #1;
               if (busy) seen = 1'b1;
            end
            if (!seen) begin
               check_val("cc_busy_rise", busy, 1);
            end else begin
               repeat (FRAME_BUSY - 1) @(posedge clk);
               #1 rd_en = 1'b1;
               @(posedge clk);
               #1 rd_en = 1'b0;
            end
         end
      join
      check_val("cc_no_ovr", overrun, model_ovr);
      for (int i = 0; i < TB_DEPTH; i++) pop_check("cc_drain");

      // Randomised frames with random errors, glitches, reads and clears
      for (int n = 0; n < 14; n++) begin
         logic [7:0] d;
         logic       pb, s0, s1;
         int         g;
         d  = 8'($urandom);
         pb = good_par(d) ^ ($urandom_range(0, 3) == 0);
         s0 = ($urandom_range(0, 4) != 0);
         s1 = ($urandom_range(0, 4) != 0);
         g  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 7)) : -1;
         send_frame(d, pb, s0, s1, g);
         check_val("rnd_ovr", overrun, model_ovr);
         repeat ($urandom_range(0, 2)) pop_check("rnd");
         if (model_ovr && ($urandom_range(0, 1) == 1)) clear_overrun("rnd_clr");
      end

      // Reset in the middle of data bit 3
      send_frame(8'h81, good_par(8'h81), 1'b1, 1'b1, -1);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      drive_bit(1'b0, 1'b0);
      drive_bit(1'b1, 1'b0);
      rx = 1'b0;
      wait_cyc(BIT_CYC / 2 - 1);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      rx = 1'b1;
      check_reset_outputs("midrst");
      exp_q.delete();
      model_ovr = 1'b0;
      wait_cyc(40);
      busy_len_q.delete();
      send_frame(8'hC3, good_par(8'hC3), 1'b1, 1'b1, -1);
      pop_check("c3");
      check_val("c3_ovr", overrun, model_ovr);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
